// File: rtl/avr_pkg.sv
// avr_pkg: shared types for the AVR serial address loader.
// Holds the loader FSM encoding and the bit-counter width helper.
package avr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/avr_addr_loader_if.sv
// avr_addr_loader_if: AVR serial link <-> SRAM address bus bundle.
// master drives si/shift_en/addr_inc/err_clr; slave drives the rest.
interface avr_addr_loader_if #(
  parameter int ADDR_W = 21
);
  logic              avr_si;
  logic              shift_en;
  logic              addr_inc;
  logic              err_clr;
  logic              avr_so;
  logic [ADDR_W-1:0] sram_addr;
  logic              addr_valid;
  logic              load_done;
  logic              frame_err;

  modport master (
    output avr_si, shift_en, addr_inc, err_clr,
    input  avr_so, sram_addr, addr_valid,
    input  load_done, frame_err
  );

  modport slave (
    input  avr_si, shift_en, addr_inc, err_clr,
    output avr_so, sram_addr, addr_valid,
    output load_done, frame_err
  );
endinterface

// File: rtl/avr_shift_reg.sv
// avr_shift_reg: W-bit shift register with optional parallel load.
// Ports: clk_i/rst_i, shift_i, si_i, load_i, pdata_i, q_o, so_o.
module avr_shift_reg #(
  parameter int W         = 21,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         shift_i,
  input  logic         si_i,
  input  logic         load_i,
  input  logic [W-1:0] pdata_i,
  output logic [W-1:0] q_o,
  output logic         so_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] base;
  logic [W-1:0] q_d;

  // Load and shift together shift the freshly loaded word.
  always_comb begin
    base = load_i ? pdata_i : q_q;
    q_d  = base;
    if (shift_i) begin
      if (MSB_FIRST) q_d = {base[W-2:0], si_i};
      else           q_d = {si_i, base[W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o  = q_q;
  assign so_o = MSB_FIRST ? q_q[W-1] : q_q[0];

endmodule

// File: rtl/avr_addr_loader.sv
// avr_addr_loader: serial address load, commit and auto-increment.
// Ports: avr_clk, reset (sync, high), bus (avr_addr_loader_if.slave).
module avr_addr_loader
  import avr_pkg::*;
#(
  parameter int ADDR_W    = 21,
  parameter bit MSB_FIRST = 1'b1,
  parameter int INC_STEP  = 1,
  parameter int ADDR_MAX  = 2**21-1
) (
  input logic               avr_clk,
  input logic               reset,
  avr_addr_loader_if.slave  bus
);

  localparam int CW = cnt_w(ADDR_W);
  localparam logic [CW-1:0] LAST = CW'(ADDR_W - 1);
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(INC_STEP);
  localparam logic [ADDR_W:0] AMAX = (ADDR_W+1)'(ADDR_MAX);

  state_e            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              sh_shift, sh_load;
  logic              rb_shift, rb_load;
  logic [ADDR_W-1:0] rb_pdata;
  logic [ADDR_W-1:0] sh_q;
  logic [ADDR_W-1:0] rb_unused;
  logic              sh_so, rb_so;
  logic [ADDR_W:0]   sum;

  avr_shift_reg #(.W(ADDR_W), .MSB_FIRST(MSB_FIRST)) u_shadow (
    .clk_i   (avr_clk),
    .rst_i   (reset),
    .shift_i (sh_shift),
    .si_i    (bus.avr_si),
    .load_i  (sh_load),
    .pdata_i ('0),
    .q_o     (sh_q),
    .so_o    (sh_so)
  );

  avr_shift_reg #(.W(ADDR_W), .MSB_FIRST(MSB_FIRST)) u_rb (
    .clk_i   (avr_clk),
    .rst_i   (reset),
    .shift_i (rb_shift),
    .si_i    (1'b0),
    .load_i  (rb_load),
    .pdata_i (rb_pdata),
    .q_o     (rb_unused),
    .so_o    (rb_so)
  );

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    err_d    = err_q;
    sh_shift = 1'b0;
    sh_load  = 1'b0;
    rb_shift = 1'b0;
    rb_load  = 1'b0;
    rb_pdata = addr_q;
    sum      = {1'b0, addr_q} + STEP;

    // Clear first so an abort in the same cycle wins.
    if (bus.err_clr) err_d = 1'b0;

    if (bus.addr_inc && st_q != COMMIT) begin
      addr_d = (sum > AMAX) ? '0 : sum[ADDR_W-1:0];
    end

    unique case (st_q)
      IDLE: begin
        // Hold rb steady once shifting starts.
        rb_load = !bus.shift_en;
        if (bus.shift_en) begin
          sh_shift = 1'b1;
          rb_shift = 1'b1;
          cnt_d    = CW'(1);
          st_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          sh_shift = 1'b1;
          rb_shift = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) st_d = COMMIT;
        end else begin
          err_d   = 1'b1;
          sh_load = 1'b1;
          rb_load = 1'b1;
          cnt_d   = '0;
          st_d    = IDLE;
        end
      end
      COMMIT: begin
        addr_d   = sh_q;
        valid_d  = 1'b1;
        // rb takes the new address so a chained frame reads it back.
        rb_load  = 1'b1;
        rb_pdata = sh_q;
        if (bus.shift_en) begin
          sh_shift = 1'b1;
          rb_shift = 1'b1;
          cnt_d    = CW'(1);
          st_d     = SHIFT;
        end else begin
          cnt_d = '0;
          st_d  = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge avr_clk) begin
    if (reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // In COMMIT rb still holds the old frame; readback comes from shadow.
  assign bus.avr_so     = (st_q == COMMIT) ? sh_so : rb_so;
  assign bus.sram_addr  = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.load_done  = (st_q == COMMIT);
  assign bus.frame_err  = err_q;

endmodule
